pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the datapath's 32-bit combinational ripple adder.
- Performs add or subtract on WIDTH-bit operands, split into STAGES carry-chained slices with one register boundary per slice.
- Produces sum, carry, overflow, zero and negative flags, using a valid/ready handshake.
- Sits in the ALU path; the CPU control unit stalls on in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth; slice width is WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clock, input, 1, rising-edge clock.
- clear, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands present this cycle.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- sub, input, 1, 0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored).
- cin, input, 1, carry-in for add.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- result, output, WIDTH, sum/difference.
- carry_out, output, 1, carry from MSB (for sub: 1 = no borrow).
- overflow, output, 1, signed overflow.
- zero, output, 1, result == 0.
- negative, output, 1, result[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clock; reset clear is synchronous and active-high. While clear is high at a rising edge, all stage valid bits go to 0. out_valid=0; result, carry_out, overflow, zero, negative = 0.
- Data registers need not reset, but outputs must read 0 while out_valid=0 after reset.
- advance = ~out_valid | out_ready. in_ready = advance (combinational); a transfer occurs when in_valid & in_ready.
- Pipeline movement: on advance, every stage shifts by one. Stage 0 loads valid = in_valid.
- Bubbles: empty slots propagate as valid=0. On ~advance, all stages hold (full backpressure, no data loss).
- Stage k (0-based):
  - adds slice k of A and B' (B' = sub ? ~b : b) plus the carry from stage k-1. Stage 0 carry = sub ? 1 : cin.
  - registers the slice sum and carry.
  - carries the not-yet-used upper slices of A and B' forward, and forwards the lower sum slices already computed.
- Latency: exactly STAGES cycles from accepted input to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Flags, computed at the last stage from the final WIDTH-bit result:
  - overflow = (a[MSB] == b'[MSB]) & (result[MSB] != a[MSB]).
  - zero and negative as defined under Ports.
- Arithmetic is modulo 2^WIDTH. Carry is not chained between transactions.
- STAGES=1: a single registered adder, latency 1.
- Simultaneous accept and emit: when out_valid & out_ready & in_valid, the new operand enters stage 0 while the last stage updates, with no bubble.
- Output stability: while out_valid & ~out_ready, result and all flags remain stable.
- Reset mid-operation: clear discards all in-flight operations. out_valid is 0 on the cycle after the clearing edge. in_ready=1 on the cycle after.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: adds input sat (1 bit), carried with each operation through the pipeline. When sat=1 and overflow=1, result is clamped: 0111..1 if a[MSB]==0, else 1000..0. The overflow flag still reports 1, and zero/negative follow the clamped result.
- Undefined: no sat port; result always wraps.

Test Plan:
- Reset: clear=1 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1 after release; first accepted op appears exactly STAGES cycles later.
- Add: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> result=0, carry_out=1, zero=1, overflow=0, after 4 cycles. Also a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, negative=1.
- Subtract: a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry_out=0, negative=1. a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, overflow=1.
- Back-to-back with backpressure: 8 ops streamed (a=i, b=i, i=0..7), out_ready low on cycles 5-7 -> in_ready low during the stall; outputs 0,2,...,14 in order, no duplicates or drops.
- Carry across slices: a=0x0000FFFF, b=0x00000001, cin=1, STAGES=4 -> result=0x00010001; repeat with WIDTH=16, STAGES=2 and STAGES=1.
- Mid-flight reset: issue 3 ops, pulse clear on cycle 2 -> no out_valid for those ops. Saturation (macro on, sat=1): 0x7FFFFFFF+1 -> 0x7FFFFFFF, overflow=1.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep add/sub pipeline, one carry-chained slice per stage, valid/ready handshake.
// Optional saturation on signed overflow when ADDSUB_SATURATE_EN is defined (adds the sat input).
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam int M  = WIDTH - 1;
  logic [WIDTH-1:0] ar [STAGES];
  logic [WIDTH-1:0] br [STAGES];
  logic [WIDTH-1:0] sr [STAGES];
  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [STAGES-1:0] vr, cr, vi, ci, nc;
  logic [SW:0] t;
  logic adv, ov;
  logic [WIDTH-1:0] fin;
`ifdef ADDSUB_SATURATE_EN
  logic [STAGES-1:0] satr, sati;
`endif
  // Stage k sees stage k-1's registers; stage 0 sees the operands with b already inverted for subtract.
  always_comb begin
    ai[0] = a;
    bi[0] = sub ? ~b : b;
    si[0] = '0;
    ci[0] = sub | cin;
    vi[0] = in_valid;
`ifdef ADDSUB_SATURATE_EN
    sati[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      ai[k] = ar[k-1];
      bi[k] = br[k-1];
      si[k] = sr[k-1];
      ci[k] = cr[k-1];
      vi[k] = vr[k-1];
`ifdef ADDSUB_SATURATE_EN
      sati[k] = satr[k-1];
`endif
    end
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, ai[k][k*SW +: SW]} + {1'b0, bi[k][k*SW +: SW]} + {{SW{1'b0}}, ci[k]};
      ns[k] = si[k];
      ns[k][k*SW +: SW] = t[SW-1:0];
      nc[k] = t[SW];
    end
  end
  always_ff @(posedge clock) begin
    if (adv) begin
      vr <= vi;
      cr <= nc;
      ar <= ai;
      br <= bi;
      sr <= ns;
`ifdef ADDSUB_SATURATE_EN
      satr <= sati;
`endif
    end
    if (clear) vr <= '0;
  end
  always_comb begin
    out_valid = vr[L];
    adv       = ~vr[L] | out_ready;
    in_ready  = adv;
    ov        = (ar[L][M] == br[L][M]) & (sr[L][M] != ar[L][M]);
`ifdef ADDSUB_SATURATE_EN
    fin       = (satr[L] & ov) ? {ar[L][M], {M{~ar[L][M]}}} : sr[L];
`else
    fin       = sr[L];
`endif
    result    = out_valid ? fin : '0;
    carry_out = out_valid & cr[L];
    overflow  = out_valid & ov;
    zero      = out_valid & (fin == '0);
    negative  = out_valid & fin[M];
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed checks of pipelined_addsub at 32/4, 16/2 and 16/1.
module tb_pipelined_addsub;
  logic clock, clear, in_valid, out_ready, sub, cin;
  logic [31:0] a, b;
  logic rdy0, ov0, v0, c0, o0, z0, n0;
  logic [31:0] r0;
  logic rdy1, v1, c1, o1, z1, n1, rdy2, v2, c2, o2, z2, n2;
  logic [15:0] r1, r2;
`ifdef ADDSUB_SATURATE_EN
  logic sat;
`endif
  int errs = 0, checks = 0, lat;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) d0 (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .sub(sub), .cin(cin),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(v0), .out_ready(out_ready), .result(r0), .carry_out(c0),
    .overflow(o0), .zero(z0), .negative(n0));
  pipelined_addsub #(.WIDTH(16), .STAGES(2)) d1 (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(rdy1), .a(a[15:0]), .b(b[15:0]),
    .sub(sub), .cin(cin),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(v1), .out_ready(out_ready), .result(r1), .carry_out(c1),
    .overflow(o1), .zero(z1), .negative(n1));
  pipelined_addsub #(.WIDTH(16), .STAGES(1)) d2 (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(rdy2), .a(a[15:0]), .b(b[15:0]),
    .sub(sub), .cin(cin),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(v2), .out_ready(out_ready), .result(r2), .carry_out(c2),
    .overflow(o2), .zero(z2), .negative(n2));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one op into an empty pipe, then block the output so every instance holds its result.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    a = x; b = y; sub = s; cin = c; in_valid = 1; out_ready = 1;
    tick;
    in_valid = 0; out_ready = 0;
    lat = 1;
    while (!v0 && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic drain;
    out_ready = 1;
    tick;
  endtask

  initial begin
    int sent, got;
    logic seen;
    clear = 1; in_valid = 1; out_ready = 1; a = 32'h1234; b = 32'h1; sub = 0; cin = 0;
`ifdef ADDSUB_SATURATE_EN
    sat = 0;
`endif
    tick; tick;
    check("rst_valid", {31'b0, v0}, 0);
    check("rst_result", r0, 0);
    check("rst_flags", {28'b0, c0, o0, z0, n0}, 0);
    check("rst_ready", {31'b0, rdy0}, 1);
    clear = 0; in_valid = 0;

    issue(32'hFFFF_FFFF, 32'h1, 0, 0);
    check("lat", lat, 4);
    check("add_wrap_res", r0, 0);
    check("add_wrap_flags", {28'b0, c0, o0, z0, n0}, 4'b1010);
    tick; tick;
    check("hold_res", r0, 0);
    check("hold_valid", {31'b0, v0}, 1);
    check("hold_ready", {31'b0, rdy0}, 0);
    drain;

    issue(32'h7FFF_FFFF, 32'h1, 0, 0);
    check("add_ovf_res", r0, 32'h8000_0000);
    check("add_ovf_flags", {28'b0, c0, o0, z0, n0}, 4'b0101);
    drain;

    issue(32'd5, 32'd7, 1, 0);
    check("sub_neg_res", r0, 32'hFFFF_FFFE);
    check("sub_neg_flags", {28'b0, c0, o0, z0, n0}, 4'b0001);
    drain;

    issue(32'h8000_0000, 32'h1, 1, 1);
    check("sub_ovf_res", r0, 32'h7FFF_FFFF);
    check("sub_ovf_flags", {28'b0, c0, o0, z0, n0}, 4'b1100);
    drain;

    issue(32'h0000_FFFF, 32'h1, 0, 1);
    check("cslice_32x4", r0, 32'h0001_0001);
    check("cslice_32x4_c", {31'b0, c0}, 0);
    check("cslice_16x2", {16'b0, r1}, 32'h0001);
    check("cslice_16x2_c", {31'b0, c1}, 1);
    check("cslice_16x1", {16'b0, r2}, 32'h0001);
    check("cslice_16x1_c", {31'b0, c2}, 1);
    drain;

    issue(32'h0000_00FF, 32'h1, 0, 0);
    check("c8_32x4", r0, 32'h0000_0100);
    check("c8_16x2", {16'b0, r1}, 32'h0100);
    check("c8_16x1", {16'b0, r2}, 32'h0100);
    drain;

    sent = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid = (sent < 8);
      a = sent; b = sent; sub = 0; cin = 0;
      #1;
      if (c >= 5 && c <= 7) check("stall_ready", {31'b0, rdy0}, 0);
      if (v0 && out_ready) begin
        check("stream", r0, 2 * got);
        got++;
      end
      if (in_valid && rdy0) sent++;
      tick;
    end
    check("stream_count", got, 8);
    in_valid = 0; out_ready = 1;

    a = 1; b = 1; in_valid = 1;
    tick;
    a = 2;
    tick;
    a = 3; clear = 1;
    tick;
    clear = 0; in_valid = 0;
    check("midrst_valid", {31'b0, v0}, 0);
    check("midrst_ready", {31'b0, rdy0}, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | v0 | v1 | v2;
      tick;
    end
    check("midrst_quiet", {31'b0, seen}, 0);

`ifdef ADDSUB_SATURATE_EN
    sat = 1;
    issue(32'h7FFF_FFFF, 32'h1, 0, 0);
    check("sat_res", r0, 32'h7FFF_FFFF);
    check("sat_flags", {28'b0, c0, o0, z0, n0}, 4'b0100);
    drain;
    issue(32'h8000_0000, 32'h1, 1, 0);
    check("sat_neg_res", r0, 32'h8000_0000);
    drain;
    sat = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
